// File: rtl/hilo_muldiv.sv
// hilo_muldiv: iterative multiply/divide unit with the HI/LO register pair.
// Multiplies by shift-add (LSB first) and divides by restoring division
// (MSB first), one bit per cycle on unsigned magnitudes. A final FIX cycle
// applies sign correction and commits to HI/LO. MTHI/MTLO write directly
// while idle.
module hilo_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             hi_we,
  output logic             lo_we,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  logic [1:0]         state_reg;
  logic [CW-1:0]      cnt_reg;
  logic               is_div_reg;
  logic               neg_res_reg;   // result (product or quotient) must be negated
  logic               neg_rem_reg;   // remainder takes the dividend's (negative) sign
  logic [WIDTH-1:0]   a_reg;         // raw dividend, returned in HI on divide by zero
  logic [WIDTH-1:0]   m_reg;         // multiplicand magnitude or divisor magnitude
  logic [WIDTH-1:0]   acc_reg;       // product high word or partial remainder
  logic [WIDTH-1:0]   q_reg;         // multiplier bits / product low word, or dividend / quotient
  logic [WIDTH-1:0]   hi_reg;
  logic [WIDTH-1:0]   lo_reg;
  logic               done_reg;
  logic               hi_we_reg;
  logic               lo_we_reg;

  logic               sign_a;
  logic               sign_b;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     mul_sel;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;
  logic [WIDTH-1:0]   acc_step;
  logic [WIDTH-1:0]   q_step;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix;
  logic [WIDTH-1:0]   rem_fix;
  logic [WIDTH-1:0]   fix_hi;
  logic [WIDTH-1:0]   fix_lo;

  assign busy   = (state_reg != S_IDLE);
  assign done   = done_reg;
  assign hi_we  = hi_we_reg;
  assign lo_we  = lo_we_reg;
  assign hi_out = hi_reg;
  assign lo_out = lo_reg;

  // Operand magnitudes; op[0]=0 selects the signed variants.
  always_comb begin
    sign_a = ~op[0] & a[WIDTH-1];
    sign_b = ~op[0] & b[WIDTH-1];
    a_mag  = sign_a ? -a : a;
    b_mag  = sign_b ? -b : b;
  end

  // One iteration of shift-add multiply or restoring divide.
  always_comb begin
    mul_sum   = {1'b0, acc_reg} + {1'b0, m_reg};
    mul_sel   = q_reg[0] ? mul_sum : {1'b0, acc_reg};
    div_shift = {acc_reg, q_reg[WIDTH-1]};
    div_diff  = div_shift - {1'b0, m_reg};
    if (is_div_reg) begin
      acc_step = div_diff[WIDTH] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0];
      q_step   = {q_reg[WIDTH-2:0], ~div_diff[WIDTH]};
    end else begin
      acc_step = mul_sel[WIDTH:1];
      q_step   = {mul_sel[0], q_reg[WIDTH-1:1]};
    end
  end

  // Sign correction and divide-by-zero override for the commit cycle.
  always_comb begin
    prod_fix = neg_res_reg ? -{acc_reg, q_reg} : {acc_reg, q_reg};
    quot_fix = neg_res_reg ? -q_reg : q_reg;
    rem_fix  = neg_rem_reg ? -acc_reg : acc_reg;
    fix_hi   = prod_fix[2*WIDTH-1:WIDTH];
    fix_lo   = prod_fix[WIDTH-1:0];
    if (is_div_reg) begin
      if (m_reg == '0) begin
        fix_hi = a_reg;
        fix_lo = '1;
      end else begin
        fix_hi = rem_fix;
        fix_lo = quot_fix;
      end
    end
  end

  // Control FSM, datapath registers and HI/LO commit.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= S_IDLE;
      cnt_reg     <= '0;
      is_div_reg  <= 1'b0;
      neg_res_reg <= 1'b0;
      neg_rem_reg <= 1'b0;
      a_reg       <= '0;
      m_reg       <= '0;
      acc_reg     <= '0;
      q_reg       <= '0;
      hi_reg      <= '0;
      lo_reg      <= '0;
      done_reg    <= 1'b0;
      hi_we_reg   <= 1'b0;
      lo_we_reg   <= 1'b0;
    end else begin
      done_reg  <= 1'b0;
      hi_we_reg <= 1'b0;
      lo_we_reg <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (start) begin
            // start has priority; a simultaneous MTHI/MTLO is dropped
            state_reg   <= S_CALC;
            cnt_reg     <= '0;
            is_div_reg  <= op[1];
            neg_res_reg <= sign_a ^ sign_b;
            neg_rem_reg <= sign_a;
            a_reg       <= a;
            acc_reg     <= '0;
            q_reg       <= op[1] ? a_mag : b_mag;
            m_reg       <= op[1] ? b_mag : a_mag;
          end else begin
            if (mthi) begin
              hi_reg    <= wdata;
              hi_we_reg <= 1'b1;
            end
            if (mtlo) begin
              lo_reg    <= wdata;
              lo_we_reg <= 1'b1;
            end
          end
        end
        S_CALC: begin
          acc_reg <= acc_step;
          q_reg   <= q_step;
          cnt_reg <= cnt_reg + 1'b1;
          if (cnt_reg == CW'(WIDTH - 1)) begin
            state_reg <= S_FIX;
          end
        end
        S_FIX: begin
          hi_reg    <= fix_hi;
          lo_reg    <= fix_lo;
          done_reg  <= 1'b1;
          hi_we_reg <= 1'b1;
          lo_we_reg <= 1'b1;
          state_reg <= S_IDLE;
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_muldiv.sv
// tb_hilo_muldiv: table-driven vectors plus hand-written corner sequences,
// expected HI/LO pushed to a scoreboard queue at launch, popped on done.
module tb_hilo_muldiv;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         mthi;
  logic         mtlo;
  logic [W-1:0] wdata;
  logic         busy;
  logic         done;
  logic         hi_we;
  logic         lo_we;
  logic [W-1:0] hi_out;
  logic [W-1:0] lo_out;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
  } vec_t;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
  } exp_t;

  exp_t sb_q[$];
  vec_t vecs[14];

  hilo_muldiv #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .mthi   (mthi),
    .mtlo   (mtlo),
    .wdata  (wdata),
    .busy   (busy),
    .done   (done),
    .hi_we  (hi_we),
    .lo_we  (lo_we),
    .hi_out (hi_out),
    .lo_out (lo_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive a start for one cycle at a negedge and push its expected result.
  task automatic launch(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic [W-1:0] ehi, input logic [W-1:0] elo);
    exp_t e;
    e.hi = ehi;
    e.lo = elo;
    sb_q.push_back(e);
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    @(negedge clk);
    start = 1'b0;
    a     = $urandom;   // operands must have been captured on the start edge
    b     = $urandom;
    op    = 2'(($urandom));
  endtask

  // Wait (bounded) for done, counting busy cycles; optionally inject an
  // ignored start+mthi at busy cycle inj.
  task automatic wait_done(input int inj);
    int   n      = 0;
    int   busy_n = 0;
    exp_t e;
    while (!done && n < 100) begin
      if (busy) busy_n++;
      if (n == inj) begin
        start = 1'b1;
        op    = 2'b11;
        mthi  = 1'b1;
        wdata = 32'h0000_1234;
      end else if (n == inj + 1) begin
        start = 1'b0;
        mthi  = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    check("done_seen", 64'(done), 64'd1);
    check("busy_cycles", 64'(busy_n), 64'd33);
    check("we_on_done", {62'd0, hi_we, lo_we}, 64'd3);
    if (sb_q.size() == 0) begin
      errors++;
      checks++;
      $display("FAIL scoreboard_empty: got 0 entries expected 1");
      e.hi = 'x;
      e.lo = 'x;
    end else begin
      e = sb_q.pop_front();
    end
    check("result_hi", 64'(hi_out), 64'(e.hi));
    check("result_lo", 64'(lo_out), 64'(e.lo));
    $display("txn: hi=%h lo=%h (expected hi=%h lo=%h) busy_cycles=%0d", hi_out, lo_out, e.hi, e.lo, busy_n);
    @(negedge clk);
    check("pulse_width", {61'd0, done, hi_we, lo_we}, 64'd0);
  endtask

  initial begin
    logic seen_done;

    vecs[0]  = '{2'b00, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1};
    vecs[1]  = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    vecs[2]  = '{2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001};
    vecs[3]  = '{2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[4]  = '{2'b11, 32'h0000_0007, 32'h0000_0000, 32'h0000_0007, 32'hFFFF_FFFF};
    vecs[5]  = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
    vecs[6]  = '{2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
    vecs[7]  = '{2'b01, 32'h1234_5678, 32'h0000_0010, 32'h0000_0001, 32'h2345_6780};
    vecs[8]  = '{2'b10, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0003};
    vecs[9]  = '{2'b10, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
    vecs[10] = '{2'b11, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 32'h0000_000E};
    vecs[11] = '{2'b10, 32'h8000_0000, 32'h0000_0000, 32'h8000_0000, 32'hFFFF_FFFF};
    vecs[12] = '{2'b00, 32'h0000_0007, 32'hFFFF_FFFA, 32'hFFFF_FFFF, 32'hFFFF_FFD6};
    vecs[13] = '{2'b11, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0000_000F, 32'h0FFF_FFFF};

    rst   = 1'b1;
    start = 1'b0;
    op    = 2'b00;
    a     = '0;
    b     = '0;
    mthi  = 1'b0;
    mtlo  = 1'b0;
    wdata = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_state", {hi_out, lo_out}, 64'd0);
    check("reset_flags", {60'd0, busy, done, hi_we, lo_we}, 64'd0);

    // Table-driven operations
    for (int i = 0; i < 14; i++) begin
      launch(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo);
      wait_done(-1);
    end

    // Start+MTHI injected mid-operation must be ignored
    launch(2'b00, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
    wait_done(10);

    // MTHI+MTLO together while idle
    mthi  = 1'b1;
    mtlo  = 1'b1;
    wdata = 32'hA5A5_A5A5;
    @(negedge clk);
    mthi = 1'b0;
    mtlo = 1'b0;
    check("mt_value", {hi_out, lo_out}, {32'hA5A5_A5A5, 32'hA5A5_A5A5});
    check("mt_flags", {61'd0, done, hi_we, lo_we}, 64'd3);
    $display("txn: mthi+mtlo hi=%h lo=%h", hi_out, lo_out);
    @(negedge clk);
    check("mt_pulse", {62'd0, hi_we, lo_we}, 64'd0);

    // start together with mtlo: the MT write is dropped
    mtlo  = 1'b1;
    wdata = 32'h0000_1111;
    launch(2'b01, 32'h0000_0002, 32'h0000_0003, 32'h0000_0000, 32'h0000_0006);
    mtlo = 1'b0;
    check("mt_dropped_lo", 64'(lo_out), 64'h0000_0000_A5A5_A5A5);
    check("mt_dropped_we", {62'd0, lo_we, busy}, 64'd1);
    wait_done(-1);

    // Reset mid-divide aborts, clears HI/LO, no done pulse
    launch(2'b10, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 32'h0000_000E);
    repeat (20) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_hilo", {hi_out, lo_out}, 64'd0);
    check("abort_flags", {60'd0, busy, done, hi_we, lo_we}, 64'd0);
    if (sb_q.size() != 0) void'(sb_q.pop_front());
    $display("txn: reset abort hi=%h lo=%h busy=%0d", hi_out, lo_out, busy);
    seen_done = 1'b0;
    repeat (40) begin
      @(negedge clk);
      seen_done = seen_done | done | hi_we | lo_we;
    end
    check("abort_no_done", 64'(seen_done), 64'd0);

    launch(2'b01, 32'h0000_0006, 32'h0000_0007, 32'h0000_0000, 32'h0000_002A);
    wait_done(-1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hilo_muldiv.md
# hilo_muldiv

Iterative multiply/divide unit and HI/LO register pair for the pipeline's EX stage; it is the producer side of the HI/LO forwarding path. It accepts MULT/MULTU/DIV/DIVU operands and computes the result over a fixed number of cycles. It commits the result to HI/LO, which MTHI/MTLO can also write directly. It drives the write-enable pulses and HI/LO values that the HI/LO forwarding unit compares against, plus a busy flag for the stall logic.

## Interface
- WIDTH, 32, operand width; HI and LO are each WIDTH bits
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  launch operation in `op` with operands `a` and `b`; honoured only in IDLE
- op  input  2  00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU
- a  input  WIDTH  multiplicand / dividend
- b  input  WIDTH  multiplier / divisor
- mthi  input  1  write `wdata` into HI
- mtlo  input  1  write `wdata` into LO
- wdata  input  WIDTH  MTHI/MTLO data
- busy  output  1  operation in flight; pipeline stalls any HI/LO access while high
- done  output  1  one-cycle pulse: a mult/div result was committed on the previous edge
- hi_we  output  1  one-cycle pulse: HI changed on the previous edge
- lo_we  output  1  one-cycle pulse: LO changed on the previous edge
- hi_out  output  WIDTH  current HI register
- lo_out  output  WIDTH  current LO register

## Operation
- States:
  - IDLE: waiting for a request.
  - CALC: 32 iterations, counter 0..31.
  - FIX: sign correction and commit.
- IDLE transitions:
  - start=1 goes to CALC.
  - Latch op and sign flags.
  - Load unsigned magnitudes |a| and |b|. Signed ops negate negative operands; 0x80000000 gives magnitude 2^31.
- IDLE, start=0, mthi/mtlo high:
  - Write wdata into HI and/or LO; both may be written in one cycle.
  - hi_we/lo_we pulse accordingly; done stays 0.
- IDLE with start and mthi/mtlo in the same cycle: start wins and the MT write is dropped.
- CALC, multiply: shift-add on a 2*WIDTH product register, one multiplier bit per cycle, LSB first.
- CALC, divide: restoring division, one quotient bit per cycle, MSB first. A WIDTH+1-bit partial remainder holds the trial subtract.
- CALC: after iteration 31, go to FIX.
- FIX, signed result:
  - MULT: product negated if the operand signs differ. HI = upper word, LO = lower word.
  - DIV: quotient negated if the signs differ; remainder takes the dividend's sign. LO = quotient, HI = remainder.
- FIX: commit to HI and LO, return to IDLE. done, hi_we and lo_we all pulse in the following cycle.
- Divide by zero (b=0, DIV or DIVU): HI = a (unmodified input value), LO = 0xFFFFFFFF. Still takes full latency.
- DIV 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0.
- start, mthi and mtlo are ignored while busy=1. No queueing, no error flag.
- Operand inputs are sampled only on the start edge; later changes have no effect.

## Timing
- Reset values:
  - state IDLE
  - hi_out = lo_out = 0
  - busy = done = hi_we = lo_we = 0
  - counter = 0
- rst mid-operation aborts on the next edge: result discarded, HI/LO cleared, no done pulse.
- busy = (state != IDLE). It rises the cycle after the start edge and stays high exactly 33 cycles (32 CALC + 1 FIX).
- Latency: start sampled at edge E0. HI/LO hold the result after edge E33. done/hi_we/lo_we are high in the cycle E33–E34.
- A new start is accepted in the same cycle done is high; back-to-back throughput is one operation per 34 cycles.
- MTHI/MTLO latency: value visible on hi_out/lo_out after the sampling edge; hi_we/lo_we high in that following cycle.
- hi_out/lo_out are registers: no combinational path from any input.

## Test plan
- MULT a=0xFFFFFFFD (-3), b=5 -> busy high 33 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFF1, done/hi_we/lo_we pulse once.
- MULTU a=b=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001. Follow with MULT of the same operands -> HI=0, LO=1.
- DIV a=0xFFFFFFF9 (-7), b=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. Then DIVU a=7, b=0 -> HI=7, LO=0xFFFFFFFF. Then DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
- Start a MULT; at cycle 10 assert start (DIVU) plus mthi with wdata=0x1234 -> both ignored; the MULT result commits at E33 unchanged.
- Idle: mthi=1, mtlo=1, wdata=0xA5A5A5A5 -> HI=LO=0xA5A5A5A5 next edge, hi_we=lo_we=1 for one cycle, done=0. Then start+mtlo together -> mtlo dropped.
- Start DIV, assert rst at cycle 20 -> next edge: busy=0, HI=LO=0, no done pulse. A fresh MULTU 6*7 then gives LO=42, HI=0.
